// File: rtl/pdm_clk_gen_stereo.sv
// PDM microphone clock generator with stereo capture on a shared data pin.
// M_CLK is produced by a runtime half-period divider; L/R samples follow each edge after a delay.
module pdm_clk_gen_stereo #(
  parameter int unsigned INPUT_FREQ   = 125000000,
  parameter int unsigned OUTPUT_FREQ  = 2500000,
  parameter int unsigned DIV_WIDTH    = 8,
  parameter int unsigned SAMPLE_DELAY = 4,
  parameter int unsigned DECIM        = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div_half,
  input  logic                 pdm_din,
  output logic                 M_CLK,
  output logic                 m_clk_rising,
  output logic                 m_clk_falling,
  output logic                 busy,
  output logic                 pdm_l,
  output logic                 pdm_r,
  output logic                 pdm_valid,
  output logic                 frame_strobe
);

  localparam int unsigned DivReset = INPUT_FREQ / OUTPUT_FREQ / 2;
  localparam int unsigned FrameW   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [FrameW-1:0] FrameLast = FrameW'(DECIM - 1);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StDrain} state_e;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] div_sel;
  logic                 mclk_q, mclk_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic                 busy_q;
  logic [FrameW-1:0]    fcnt_q, fcnt_d;
  logic                 frame_q, frame_d;
  logic                 last_cnt;

  logic s1_q, s2_q;
  logic pdm_l_q, pdm_r_q, valid_q;
  logic rise_dly, fall_dly;

  assign div_sel  = (div_half == '0) ? DIV_WIDTH'(1) : div_half;
  assign last_cnt = (cnt_q == div_q - DIV_WIDTH'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    mclk_d  = mclk_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        mclk_d = 1'b0;
        if (en) begin
          div_d   = div_sel;
          state_d = StLow;
        end
      end
      StLow: begin
        // Leaving from LOW is glitch-free because M_CLK is already 0.
        if (!en) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (last_cnt) begin
          mclk_d  = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
          state_d = StHigh;
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end
      StHigh, StDrain: begin
        if (last_cnt) begin
          mclk_d = 1'b0;
          fall_d = 1'b1;
          cnt_d  = '0;
          if (en) begin
            div_d   = div_sel;
            state_d = StLow;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d   = cnt_q + DIV_WIDTH'(1);
          state_d = en ? StHigh : StDrain;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fcnt_d  = fcnt_q;
    frame_d = 1'b0;
    if (state_q == StIdle) begin
      fcnt_d = '0;
    end else if (rise_d) begin
      if (fcnt_q == FrameLast) begin
        fcnt_d  = '0;
        frame_d = 1'b1;
      end else begin
        fcnt_d = fcnt_q + FrameW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      div_q   <= DIV_WIDTH'(DivReset);
      mclk_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
      fcnt_q  <= '0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      mclk_q  <= mclk_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= (state_d != StIdle);
      fcnt_q  <= fcnt_d;
      frame_q <= frame_d;
    end
  end

  if (SAMPLE_DELAY > 0) begin : g_dly
    logic [SAMPLE_DELAY-1:0] rise_sr_q, fall_sr_q;

    // Keeps shifting in IDLE so the last L/R pair still completes.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rise_sr_q <= '0;
        fall_sr_q <= '0;
      end else begin
        rise_sr_q[0] <= rise_q;
        fall_sr_q[0] <= fall_q;
        for (int i = 1; i < SAMPLE_DELAY; i++) begin
          rise_sr_q[i] <= rise_sr_q[i-1];
          fall_sr_q[i] <= fall_sr_q[i-1];
        end
      end
    end

    assign rise_dly = rise_sr_q[SAMPLE_DELAY-1];
    assign fall_dly = fall_sr_q[SAMPLE_DELAY-1];
  end else begin : g_nodly
    assign rise_dly = rise_q;
    assign fall_dly = fall_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      pdm_l_q <= 1'b0;
      pdm_r_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s1_q    <= pdm_din;
      s2_q    <= s1_q;
      if (rise_dly) pdm_l_q <= s2_q;
      if (fall_dly) pdm_r_q <= s2_q;
      valid_q <= fall_dly;
    end
  end

  assign M_CLK         = mclk_q;
  assign m_clk_rising  = rise_q;
  assign m_clk_falling = fall_q;
  assign busy          = busy_q;
  assign pdm_l         = pdm_l_q;
  assign pdm_r         = pdm_r_q;
  assign pdm_valid     = valid_q;
  assign frame_strobe  = frame_q;

endmodule
